// File: rtl/game_pkg.sv
// Shared definitions for the game status tracker: state encoding, default
// game rules and a small event-counting helper.
package game_pkg;

  // Tracker state encoding; the numeric values are visible on debug taps.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_C = 2'd1,
    ST_RUN_I = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // Default game rules.
  localparam int unsigned LIVES_INIT_DEF     = 3;
  localparam int unsigned LIVES_MAX_DEF      = 7;
  localparam int unsigned KILL_TARGET_DEF    = 20;
  localparam int unsigned CLASSIC_TIME_S_DEF = 120;
  localparam int unsigned SCORE_PER_KILL_DEF = 10;

  // Number of enemies destroyed in one cycle (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage : game_pkg

// File: rtl/sec_tick_gen.sv
// One-second prescaler: emits a single-cycle tick on every CLK_FREQ-th
// enabled cycle and restarts from zero whenever it is disabled.
module sec_tick_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_o
);

  localparam int unsigned       CNT_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at the last cycle of a second, clear while disabled.
  // NOTE: every signal written in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The tick marks the cycle in which the counter wraps.
  assign tick_o = en && (cnt_q == CNT_MAX);

  // Counter register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the reset is synchronous, so it lives inside the clocked
  // branch and has no entry in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sec_tick_gen

// File: rtl/game_status_tracker.sv
// Game status tracker: counts lives, kills, score and the classic countdown
// while a game runs, and raises a held gameover level towards the mode
// controller when the game ends.
module game_status_tracker
  import game_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned LIVES_INIT     = LIVES_INIT_DEF,
  parameter int unsigned LIVES_MAX      = LIVES_MAX_DEF,
  parameter int unsigned KILL_TARGET    = KILL_TARGET_DEF,
  parameter int unsigned CLASSIC_TIME_S = CLASSIC_TIME_S_DEF,
  parameter int unsigned SCORE_PER_KILL = SCORE_PER_KILL_DEF,
  parameter int unsigned SCORE_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_game_classic,
  input  logic               enable_game_infinity,
  input  logic               mytank_hit,
  input  logic [3:0]         enytank_kill,
  input  logic               reward_life,
  output logic               gameover_classic,
  output logic               gameover_infinity,
  output logic               game_won,
  output logic [2:0]         lives,
  output logic [7:0]         kills,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left
);

  localparam logic [2:0] LIVES_INIT_L   = 3'(LIVES_INIT);
  localparam logic [2:0] LIVES_MAX_L    = 3'(LIVES_MAX);
  localparam logic [7:0] KILL_TARGET_L  = 8'(KILL_TARGET);
  localparam logic [7:0] CLASSIC_TIME_L = 8'(CLASSIC_TIME_S);
  // Score sum is computed wide enough that neither the per-cycle increment
  // nor the carry out of the score register can wrap before saturation.
  localparam int unsigned SUM_W = ((SCORE_W > 32) ? SCORE_W : 32) + 4;

  game_state_e state_q, state_d;

  logic [2:0]         lives_q, lives_d;
  logic [7:0]         kills_q, kills_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         time_q, time_d;
  logic               go_c_q, go_c_d;
  logic               go_i_q, go_i_d;
  logic               won_q, won_d;

  // Candidate values after this cycle's events, before the FSM decides.
  logic [2:0]         nxt_lives;
  logic [7:0]         nxt_kills;
  logic [SCORE_W-1:0] nxt_score;
  logic [7:0]         nxt_time;
  logic [2:0]         kill_cnt;
  logic [8:0]         kills_sum;
  logic [SUM_W-1:0]   score_add;
  logic [SUM_W-1:0]   score_sum;

  logic classic_run;
  logic mode_en;
  logic lost;
  logic win;
  logic timed_out;
  logic sec_en;
  logic sec_tick;

  // The countdown only advances while a classic game runs.
  assign sec_en      = (state_q == ST_RUN_C);
  assign classic_run = (state_q == ST_RUN_C);
  assign mode_en     = classic_run ? enable_game_classic : enable_game_infinity;

  sec_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_sec_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_en),
    .tick_o (sec_tick)
  );

  // Event arithmetic: clamped lives, saturating kills/score, floored timer.
  always_comb begin
    nxt_lives = lives_q;
    if (mytank_hit && !reward_life) begin
      nxt_lives = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
    end else if (reward_life && !mytank_hit) begin
      nxt_lives = (lives_q >= LIVES_MAX_L) ? LIVES_MAX_L : lives_q + 3'd1;
    end

    kill_cnt  = popcount4(enytank_kill);
    kills_sum = {1'b0, kills_q} + {6'd0, kill_cnt};
    nxt_kills = kills_sum[8] ? 8'hFF : kills_sum[7:0];

    score_add = SUM_W'(kill_cnt) * SUM_W'(SCORE_PER_KILL);
    score_sum = SUM_W'(score_q) + score_add;
    nxt_score = (|score_sum[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    nxt_time = time_q;
    if (sec_tick && (time_q != 8'd0)) begin
      nxt_time = time_q - 8'd1;
    end
  end

  // End conditions look at the post-event values; lives loss outranks a win,
  // which outranks a timeout.
  assign lost      = (nxt_lives == 3'd0);
  assign win       = classic_run && (nxt_kills >= KILL_TARGET_L);
  assign timed_out = classic_run && (nxt_time == 8'd0);

  // Game FSM: next state and next register values.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    kills_d = kills_q;
    score_d = score_q;
    time_d  = time_q;
    go_c_d  = go_c_q;
    go_i_d  = go_i_q;
    won_d   = won_q;

    case (state_q)
      ST_IDLE: begin
        lives_d = LIVES_INIT_L;
        kills_d = '0;
        score_d = '0;
        time_d  = enable_game_classic ? CLASSIC_TIME_L : 8'd0;
        go_c_d  = 1'b0;
        go_i_d  = 1'b0;
        won_d   = 1'b0;
        if (enable_game_classic) begin
          state_d = ST_RUN_C;
        end else if (enable_game_infinity) begin
          state_d = ST_RUN_I;
        end
      end

      ST_RUN_C, ST_RUN_I: begin
        if (!mode_en) begin
          // Game abandoned by the mode controller: no gameover reported.
          state_d = ST_IDLE;
        end else begin
          lives_d = nxt_lives;
          kills_d = nxt_kills;
          score_d = nxt_score;
          time_d  = nxt_time;
          if (lost || win || timed_out) begin
            state_d = ST_OVER;
            go_c_d  = classic_run;
            go_i_d  = !classic_run;
            won_d   = !lost && win;
          end
        end
      end

      ST_OVER: begin
        // Hold the result until the mode controller has dropped both enables.
        if (!enable_game_classic && !enable_game_infinity) begin
          state_d = ST_IDLE;
          go_c_d  = 1'b0;
          go_i_d  = 1'b0;
          won_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lives_q <= '0;
      kills_q <= '0;
      score_q <= '0;
      time_q  <= '0;
      go_c_q  <= 1'b0;
      go_i_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      kills_q <= kills_d;
      score_q <= score_d;
      time_q  <= time_d;
      go_c_q  <= go_c_d;
      go_i_q  <= go_i_d;
      won_q   <= won_d;
    end
  end

  assign gameover_classic  = go_c_q;
  assign gameover_infinity = go_i_q;
  assign game_won          = won_q;
  assign lives             = lives_q;
  assign kills             = kills_q;
  assign score             = score_q;
  assign time_left         = time_q;

endmodule : game_status_tracker
